// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 values and the ALU operation set.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // SUB exists only in register form; bit 30 of an OP-IMM is immediate data except for SRAI.
    function automatic alu_op_t f_alu_op(input logic [2:0] funct3, input logic alt, input logic is_reg);
        alu_op_t op;
        op = ALU_ADD;
        case (funct3)
            F3_ADD_SUB: op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_core_if.sv
// Retirement/writeback port of rv32i_core; the core drives it, trace and bench consume it.
interface rv32i_core_if;
    logic        inst_v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rd_v;
    logic [4:0]  rd;
    logic [31:0] rd_data;

    modport master (output inst_v, pc, inst, rd_v, rd, rd_data);
    modport slave  (input  inst_v, pc, inst, rd_v, rd, rd_data);
endinterface

// File: rtl/rv32i_alu.sv
// Combinational RV32I integer ALU; shift amounts use the low 5 bits of b.
module rv32i_alu
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         alu_op,
    output logic [XLEN-1:0] y
);

    // operation select
    always_comb begin
        y = a + b;
        case (alu_op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
    end

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with a unified instruction/data memory.
// Define RV32I_CORE_TRACE_EN to print one trace line per retired instruction.
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter int MEM_AW = 14,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] reset_pc,
    rv32i_core_if.master    retire
);

    localparam int AW = MEM_AW + 2;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_mem [2**MEM_AW];
    logic [XLEN-1:0] r_rf  [32];

    logic [XLEN-1:0] w_inst, w_rs1_val, w_rs2_val;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_alu_b, w_alu_y, w_jalr_sum;
    alu_op_t         w_alu_op;
    logic [11:0]     w_ls_off;
    logic [AW-1:0]   w_ls_addr;
    logic [XLEN-1:0] w_ld_word, w_ld_data;
    logic [7:0]      w_ld_byte;
    logic [15:0]     w_ld_half;
    logic            w_take, w_we, w_rf_we;
    logic [XLEN-1:0] w_next_pc, w_rd_data, w_st_data;
    logic [3:0]      w_st_be;

    assign w_inst   = r_mem[r_pc[MEM_AW+1:2]];
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_f3     = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'h000};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    assign w_rs1_val = (w_rs1 == 5'd0) ? {XLEN{1'b0}} : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? {XLEN{1'b0}} : r_rf[w_rs2];

    assign w_alu_b  = (w_opcode == OP_OP) ? w_rs2_val : w_imm_i;
    assign w_alu_op = f_alu_op(w_f3, w_inst[30], (w_opcode == OP_OP));

    rv32i_alu #(.XLEN(XLEN)) u_alu (
        .a      (w_rs1_val),
        .b      (w_alu_b),
        .alu_op (w_alu_op),
        .y      (w_alu_y)
    );

    assign w_jalr_sum = w_rs1_val + w_imm_i;

    // Only the memory-indexing address bits are formed, so higher bits alias.
    assign w_ls_off  = (w_opcode == OP_STORE) ? {w_inst[31:25], w_inst[11:7]} : w_inst[31:20];
    assign w_ls_addr = w_rs1_val[AW-1:0] + {{(AW-12){w_ls_off[11]}}, w_ls_off};
    assign w_ld_word = r_mem[w_ls_addr[AW-1:2]];
    assign w_ld_byte = w_ld_word[{w_ls_addr[1:0], 3'b000} +: 8];
    assign w_ld_half = w_ls_addr[1] ? w_ld_word[31:16] : w_ld_word[15:0];

    // load extraction and extension
    always_comb begin
        w_ld_data = w_ld_word;
        case (w_f3)
            F3_LB:   w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            F3_LH:   w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            F3_LW:   w_ld_data = w_ld_word;
            F3_LBU:  w_ld_data = {24'h000000, w_ld_byte};
            F3_LHU:  w_ld_data = {16'h0000, w_ld_half};
            default: w_ld_data = w_ld_word;
        endcase
    end

    // branch condition
    always_comb begin
        w_take = 1'b0;
        case (w_f3)
            F3_BEQ:  w_take = (w_rs1_val == w_rs2_val);
            F3_BNE:  w_take = (w_rs1_val != w_rs2_val);
            F3_BLT:  w_take = ($signed(w_rs1_val) < $signed(w_rs2_val));
            F3_BGE:  w_take = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            F3_BLTU: w_take = (w_rs1_val < w_rs2_val);
            F3_BGEU: w_take = (w_rs1_val >= w_rs2_val);
            default: w_take = 1'b0;
        endcase
    end

    // decode: next PC and writeback value; FENCE, SYSTEM and unknown opcodes are NOPs
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        w_we      = 1'b0;
        w_rd_data = w_alu_y;
        case (w_opcode)
            OP_LUI:    begin w_we = 1'b1; w_rd_data = w_imm_u; end
            OP_AUIPC:  begin w_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
            OP_JAL:    begin w_we = 1'b1; w_rd_data = r_pc + 32'd4; w_next_pc = r_pc + w_imm_j; end
            OP_JALR:   begin w_we = 1'b1; w_rd_data = r_pc + 32'd4; w_next_pc = {w_jalr_sum[XLEN-1:1], 1'b0}; end
            OP_BRANCH: begin
                if (w_take) begin
                    w_next_pc = r_pc + w_imm_b;
                end else begin
                    w_next_pc = r_pc + 32'd4;
                end
            end
            OP_LOAD:   begin w_we = 1'b1; w_rd_data = w_ld_data; end
            OP_IMM:    begin w_we = 1'b1; w_rd_data = w_alu_y; end
            OP_OP:     begin w_we = 1'b1; w_rd_data = w_alu_y; end
            default:   begin w_we = 1'b0; end
        endcase
    end

    assign w_rf_we = w_we && (w_rd != 5'd0) && !reset;

    // store lane enables and replicated store data
    always_comb begin
        w_st_be   = 4'b0000;
        w_st_data = w_rs2_val;
        if ((w_opcode == OP_STORE) && !reset) begin
            case (w_f3)
                F3_SB:   begin w_st_be = 4'b0001 << w_ls_addr[1:0]; w_st_data = {4{w_rs2_val[7:0]}}; end
                F3_SH:   begin w_st_be = w_ls_addr[1] ? 4'b1100 : 4'b0011; w_st_data = {2{w_rs2_val[15:0]}}; end
                F3_SW:   begin w_st_be = 4'b1111; end
                default: begin w_st_be = 4'b0000; end
            endcase
        end else begin
            w_st_be = 4'b0000;
        end
    end

    // program counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= reset_pc;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // register file write; x0 is never written
    always_ff @(posedge clk) begin
        if (w_rf_we) begin
            r_rf[w_rd] <= w_rd_data;
        end
    end

    // byte-enable memory write
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_st_be[i]) begin
                r_mem[w_ls_addr[AW-1:2]][8*i +: 8] <= w_st_data[8*i +: 8];
            end
        end
    end

    assign retire.inst_v  = !reset;
    assign retire.pc      = r_pc;
    assign retire.inst    = w_inst;
    assign retire.rd_v    = w_rf_we;
    assign retire.rd      = w_rd;
    assign retire.rd_data = w_rd_data;

`ifdef RV32I_CORE_TRACE_EN
    // trace line per retired instruction
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_rf_we) begin
                $display("%08h %08h x%0d=%08h", r_pc, w_inst, w_rd, w_rd_data);
            end else begin
                $display("%08h %08h", r_pc, w_inst);
            end
        end
    end
`else
    // trace disabled: no simulation output
`endif

endmodule

// File: tb/tb_rv32i_core.sv
// Scoreboard bench for rv32i_core: directed programs preloaded into memory, expected retirements queued.
module tb_rv32i_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] reset_pc = 32'h0000_0000;

    rv32i_core_if rif ();

    rv32i_core dut (
        .clk      (clk),
        .reset    (reset),
        .reset_pc (reset_pc),
        .retire   (rif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rd_v;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] img [logic [31:0]];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] pc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at pc %08h: got %08h expected %08h", name, pc, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        img[a] = w;
        dut.r_mem[a[15:2]] <= w;
    endtask

    task automatic ex(input logic [31:0] pc, input logic rdv, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.pc   = pc;
        e.inst = img[pc];
        e.rd_v = rdv;
        e.rd   = rd;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Hold reset two edges, then release for exactly as many cycles as retirements queued.
    task automatic run(input logic [31:0] pc0);
        int n;
        n = sb_q.size();
        reset = 1'b1;
        reset_pc = pc0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b1;
    endtask

    // monitor: compare every sampled cycle against reset state or the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_inst_v", rif.pc, {31'd0, rif.inst_v}, 32'd0);
                chk("reset_rd_v", rif.pc, {31'd0, rif.rd_v}, 32'd0);
            end else if (sb_q.size() == 0) begin
                chk("unexpected_retire", rif.pc, {31'd0, rif.inst_v}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("inst_v", e.pc, {31'd0, rif.inst_v}, 32'd1);
                chk("pc", e.pc, rif.pc, e.pc);
                chk("inst", e.pc, rif.inst, e.inst);
                chk("rd_v", e.pc, {31'd0, rif.rd_v}, {31'd0, e.rd_v});
                if (e.rd_v) begin
                    chk("rd", e.pc, {27'd0, rif.rd}, {27'd0, e.rd});
                    chk("rd_data", e.pc, rif.rd_data, e.data);
                end
            end
        end
    end

    initial begin
        // reset / first retire
        put(32'h080, 32'h0000_0013); put(32'h084, 32'h0000_0013);
        // ALU and x0
        put(32'h040, 32'hFFF0_0093); put(32'h044, 32'h0040_D113); put(32'h048, 32'h4040_D193);
        put(32'h04C, 32'h0050_0013); put(32'h050, 32'h4011_0233); put(32'h054, 32'h0021_A2B3);
        put(32'h058, 32'h0021_B333); put(32'h05C, 32'h0011_43B3); put(32'h060, 32'h0230_0493);
        put(32'h064, 32'h0091_1433); put(32'h068, 32'h0000_1517); put(32'h06C, 32'h8000_05B7);
        // branch / jump
        put(32'h100, 32'h0000_0463); put(32'h104, 32'h0000_0013); put(32'h108, 32'hFF9F_F0EF);
        put(32'h180, 32'h2010_0613); put(32'h184, 32'h0006_06E7); put(32'h200, 32'h0000_1463);
        put(32'h204, 32'h00C0_6463); put(32'h208, 32'h0000_0013); put(32'h20C, 32'h00C0_5463);
        put(32'h210, 32'h0000_0013);
        // load/store lanes, aliasing, SYSTEM/unknown, self-loop
        put(32'h280, 32'h80FF_8A37); put(32'h284, 32'hF01A_0A13); put(32'h288, 32'h4000_0A93);
        put(32'h28C, 32'h014A_A023); put(32'h290, 32'h003A_8B03); put(32'h294, 32'h003A_CB83);
        put(32'h298, 32'h002A_9C03); put(32'h29C, 32'h000A_DC83); put(32'h2A0, 32'h0AA0_0D13);
        put(32'h2A4, 32'h01AA_80A3); put(32'h2A8, 32'h000A_AD83); put(32'h2AC, 32'h01AA_9123);
        put(32'h2B0, 32'h000A_AE03); put(32'h2B4, 32'h0001_0F37); put(32'h2B8, 32'h015F_0F33);
        put(32'h2BC, 32'h000F_2F83); put(32'h2C0, 32'h0000_0073); put(32'h2C4, 32'h0000_0000);
        put(32'h2C8, 32'h0000_000F); put(32'h2CC, 32'h3000_20F3); put(32'h2D0, 32'h0300_006F);
        put(32'h300, 32'h0000_0063); put(32'h400, 32'h0000_0000);

        @(posedge clk); #1;

        ex(32'h080, 1'b0, 5'd0, 32'h0); ex(32'h084, 1'b0, 5'd0, 32'h0);
        run(32'h0000_0080);

        ex(32'h040, 1'b1, 5'd1, 32'hFFFF_FFFF); ex(32'h044, 1'b1, 5'd2, 32'h0FFF_FFFF);
        ex(32'h048, 1'b1, 5'd3, 32'hFFFF_FFFF); ex(32'h04C, 1'b0, 5'd0, 32'h0);
        ex(32'h050, 1'b1, 5'd4, 32'h1000_0000); ex(32'h054, 1'b1, 5'd5, 32'h0000_0001);
        ex(32'h058, 1'b1, 5'd6, 32'h0000_0000); ex(32'h05C, 1'b1, 5'd7, 32'hF000_0000);
        ex(32'h060, 1'b1, 5'd9, 32'h0000_0023); ex(32'h064, 1'b1, 5'd8, 32'h7FFF_FFF8);
        ex(32'h068, 1'b1, 5'd10, 32'h0000_1068); ex(32'h06C, 1'b1, 5'd11, 32'h8000_0000);
        run(32'h0000_0040);

        ex(32'h100, 1'b0, 5'd0, 32'h0); ex(32'h108, 1'b1, 5'd1, 32'h0000_010C);
        ex(32'h100, 1'b0, 5'd0, 32'h0);
        run(32'h0000_0100);

        ex(32'h180, 1'b1, 5'd12, 32'h0000_0201); ex(32'h184, 1'b1, 5'd13, 32'h0000_0188);
        ex(32'h200, 1'b0, 5'd0, 32'h0); ex(32'h204, 1'b0, 5'd0, 32'h0);
        ex(32'h20C, 1'b0, 5'd0, 32'h0); ex(32'h210, 1'b0, 5'd0, 32'h0);
        run(32'h0000_0180);

        ex(32'h280, 1'b1, 5'd20, 32'h80FF_8000); ex(32'h284, 1'b1, 5'd20, 32'h80FF_7F01);
        ex(32'h288, 1'b1, 5'd21, 32'h0000_0400); ex(32'h28C, 1'b0, 5'd0, 32'h0);
        ex(32'h290, 1'b1, 5'd22, 32'hFFFF_FF80); ex(32'h294, 1'b1, 5'd23, 32'h0000_0080);
        ex(32'h298, 1'b1, 5'd24, 32'hFFFF_80FF); ex(32'h29C, 1'b1, 5'd25, 32'h0000_7F01);
        ex(32'h2A0, 1'b1, 5'd26, 32'h0000_00AA); ex(32'h2A4, 1'b0, 5'd0, 32'h0);
        ex(32'h2A8, 1'b1, 5'd27, 32'h80FF_AA01); ex(32'h2AC, 1'b0, 5'd0, 32'h0);
        ex(32'h2B0, 1'b1, 5'd28, 32'h00AA_AA01); ex(32'h2B4, 1'b1, 5'd30, 32'h0001_0000);
        ex(32'h2B8, 1'b1, 5'd30, 32'h0001_0400); ex(32'h2BC, 1'b1, 5'd31, 32'h00AA_AA01);
        ex(32'h2C0, 1'b0, 5'd0, 32'h0); ex(32'h2C4, 1'b0, 5'd0, 32'h0);
        ex(32'h2C8, 1'b0, 5'd0, 32'h0); ex(32'h2CC, 1'b0, 5'd0, 32'h0);
        ex(32'h2D0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) ex(32'h300, 1'b0, 5'd0, 32'h0);
        run(32'h0000_0280);

        @(posedge clk); #1;
        chk("scoreboard_drained", 32'h0, sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
